debug_sequencer: RTL and testbench

Debug run/step sequencer for the pipelined MIPS core. It decodes single-byte UART commands and gates the core clock enable, either free-running until `halt` or for exactly one cycle. After every run or step it streams a 196-byte state dump over the UART transmitter: the PC, then 32 registers, then 16 data-memory words. It sits between the `uart` block, the collector and the clock gate that drives the core clock.

---
 rtl/debug_pkg.sv | 28 ++
 rtl/debug_sequencer_word_serializer.sv | 41 ++++
 rtl/debug_sequencer.sv | 123 ++++++++++++
 tb/tb_debug_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
`default_nettype none
// debug_pkg: shared state encoding, command bytes and dump-length helper
// for the debug run/step sequencer.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_STEP    = 3'd2,
    ST_LOAD    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  localparam logic [7:0] DBG_CMD_RUN  = 8'h52;
  localparam logic [7:0] DBG_CMD_STEP = 8'h53;

  localparam int DBG_N_REGS = 32;
  localparam int DBG_N_MEM  = 16;
  localparam int N_WORDS    = 1 + DBG_N_REGS + DBG_N_MEM;

  // Dump length in words: PC, then registers, then memory words.
  function automatic int n_words(input int n_regs, input int n_mem);
    return 1 + n_regs + n_mem;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debug_sequencer_word_serializer.sv
`default_nettype none
// word_serializer: holds one dump word and presents it LSB-byte first,
// with a byte counter that flags the final byte of the word.
module word_serializer #(
  parameter int LEN     = 32,
  parameter int NB_DATA = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [LEN-1:0]     word,
  input  logic               shift,
  output logic [NB_DATA-1:0] tx_data,
  output logic               last_byte
);

  localparam int NBYTES = LEN / NB_DATA;
  localparam int CW     = $clog2(NBYTES) + 1;

  logic [LEN-1:0] shreg;
  logic [CW-1:0]  byte_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      shreg    <= word;
      byte_cnt <= '0;
    end else if (shift) begin
      shreg <= shreg >> NB_DATA;
      // Saturate so the counter can never wrap past the last byte.
      if (!last_byte) byte_cnt <= byte_cnt + 1'b1;
    end
  end

  assign tx_data   = shreg[NB_DATA-1:0];
  assign last_byte = (byte_cnt == CW'(NBYTES - 1));

endmodule
`default_nettype wire

// File: rtl/debug_sequencer.sv
`default_nettype none
// debug_sequencer: UART-command run/step gating of the core clock enable,
// followed by a PC/register/memory state dump over the UART transmitter.
module debug_sequencer
  import debug_pkg::*;
#(
  parameter int                 LEN      = 32,
  parameter int                 NB_DATA  = 8,
  parameter int                 N_REGS   = 32,
  parameter int                 N_MEM    = 16,
  parameter logic [NB_DATA-1:0] CMD_RUN  = NB_DATA'(DBG_CMD_RUN),
  parameter logic [NB_DATA-1:0] CMD_STEP = NB_DATA'(DBG_CMD_STEP)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_done,
  input  logic [NB_DATA-1:0] rx_data,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [NB_DATA-1:0] tx_data,
  input  logic               halt,
  input  logic [LEN-1:0]     pc,
  output logic               clk_en,
  output logic [5:0]         word_addr,
  input  logic [LEN-1:0]     word_in,
  output logic               busy
);

  localparam int TOTAL_WORDS = n_words(N_REGS, N_MEM);
  localparam int IDX_W       = $clog2(TOTAL_WORDS);
  localparam int LAST_ADDR   = N_REGS + N_MEM - 1;

  state_t           state, state_next;
  logic [IDX_W-1:0] index;
  logic             ser_load, ser_shift, last_byte, index_inc;
  logic [LEN-1:0]   load_word;
  logic [5:0]       next_addr;

  // Collector address for the word after the one being loaded, so word_in
  // has settled long before the next LOAD samples it.
  assign next_addr = (index >= IDX_W'(LAST_ADDR)) ? 6'(LAST_ADDR) : 6'(index);
  assign load_word = (index == '0) ? pc : word_in;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      index     <= '0;
      word_addr <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE) begin
        index     <= '0;
        word_addr <= '0;
      end else begin
        if (ser_load)  word_addr <= next_addr;
        if (index_inc) index     <= index + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    clk_en     = 1'b0;
    tx_start   = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    index_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_done) begin
          if (rx_data == CMD_RUN)       state_next = ST_RUN;
          else if (rx_data == CMD_STEP) state_next = ST_STEP;
        end
      end
      ST_RUN: begin
        clk_en = ~halt;
        if (halt) state_next = ST_LOAD;
      end
      ST_STEP: begin
        clk_en     = ~halt;
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        ser_load   = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        tx_start   = 1'b1;
        state_next = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_done) begin
          ser_shift = 1'b1;
          if (!last_byte) begin
            state_next = ST_SEND;
          end else if (index != IDX_W'(TOTAL_WORDS - 1)) begin
            index_inc  = 1'b1;
            state_next = ST_LOAD;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  word_serializer #(
    .LEN     (LEN),
    .NB_DATA (NB_DATA)
  ) u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .word      (load_word),
    .shift     (ser_shift),
    .tx_data   (tx_data),
    .last_byte (last_byte)
  );

endmodule
`default_nettype wire

// File: tb/tb_debug_sequencer.sv
`default_nettype none
// tb_debug_sequencer: directed scenarios for the run/step sequencer with a
// registered collector model and a delay-programmable UART transmitter model.
module tb_debug_sequencer;

  logic        clk = 1'b0;
  logic        reset, rx_done, tx_done, halt;
  logic        tx_start, clk_en, busy;
  logic [7:0]  rx_data, tx_data;
  logic [31:0] pc, word_in;
  logic [5:0]  word_addr;

  int vectors     = 0;
  int miscompares = 0;

  int tx_delay  = 0;
  int tx_wait   = -1;
  int nbytes    = 0;
  int en_cycles = 0;
  int unstable  = 0;
  bit pending   = 1'b0;
  logic [7:0] held;
  logic [7:0] cap [0:255];

  always #5 clk = ~clk;

  debug_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .tx_done   (tx_done),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .halt      (halt),
    .pc        (pc),
    .clk_en    (clk_en),
    .word_addr (word_addr),
    .word_in   (word_in),
    .busy      (busy)
  );

  // Collector: registered lookup returning addr*0x01010101.
  always @(posedge clk) word_in <= {4{{2'b00, word_addr}}};

  // Transmitter: tx_done pulse tx_delay+1 cycles after the tx_start cycle.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      tx_done = 1'b0;
      if (!reset) begin
        tx_wait = -1;
      end else begin
        if (tx_wait > 0) tx_wait--;
        else if (tx_wait == 0) begin tx_done = 1'b1; tx_wait = -1; end
        if (tx_start) tx_wait = tx_delay;
      end
    end
  end

  // Monitor sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (clk_en === 1'b1) en_cycles++;
      if (!reset) begin
        pending = 1'b0;
      end else if (tx_start === 1'b1) begin
        if (nbytes < 256) cap[nbytes] = tx_data;
        nbytes++;
        pending = 1'b1;
        held    = tx_data;
      end else if (pending) begin
        if (tx_data !== held) unstable++;
        if (tx_done) pending = 1'b0;
      end
    end
  end

  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] pcv);
    logic [31:0] w;
    int wi;
    wi = i / 4;
    if (wi == 0) w = pcv;
    else         w = 32'(wi - 1) * 32'h0101_0101;
    return w[8*(i%4) +: 8];
  endfunction

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    step();
    rx_done = 1'b1;
    rx_data = b;
    step();
    rx_done = 1'b0;
  endtask

  task automatic clear_stats();
    nbytes = 0; en_cycles = 0; unstable = 0;
    for (int i = 0; i < 256; i++) cap[i] = 8'hxx;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy && n < budget) begin step(); n++; end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; rx_done = 1'b0; rx_data = 8'h00; halt = 1'b0; pc = 32'h0;
    repeat (3) step();
    vectors += 5;
    if (clk_en   !== 1'b0)  begin miscompares++; $display("FAIL rst_clk_en: got %b, want 0", clk_en); end
    if (tx_start !== 1'b0)  begin miscompares++; $display("FAIL rst_tx_start: got %b, want 0", tx_start); end
    if (tx_data  !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data: got %h, want 00", tx_data); end
    if (word_addr !== 6'd0) begin miscompares++; $display("FAIL rst_word_addr: got %0d, want 0", word_addr); end
    if (busy     !== 1'b0)  begin miscompares++; $display("FAIL rst_busy: got %b, want 0", busy); end
    reset = 1'b1;
    repeat (2) step();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_release_busy: got %b, want 0", busy); end
  endtask

  task automatic test_step();
    int errs;
    pc = 32'h0000_0004; halt = 1'b0; tx_delay = 0;
    clear_stats();
    send_cmd(8'h53);
    vectors += 2;
    if (clk_en !== 1'b1) begin miscompares++; $display("FAIL step_clk_en: got %b, want 1", clk_en); end
    if (busy   !== 1'b1) begin miscompares++; $display("FAIL step_busy: got %b, want 1", busy); end
    step();
    vectors += 2;
    if (clk_en   !== 1'b0) begin miscompares++; $display("FAIL step_load_clk_en: got %b, want 0", clk_en); end
    if (tx_start !== 1'b0) begin miscompares++; $display("FAIL step_load_tx_start: got %b, want 0", tx_start); end
    step();
    vectors += 2;
    if (tx_start !== 1'b1)  begin miscompares++; $display("FAIL step_first_tx_start: got %b, want 1", tx_start); end
    if (tx_data  !== 8'h04) begin miscompares++; $display("FAIL step_first_byte: got %h, want 04", tx_data); end
    wait_idle(2000, "step");
    errs = 0;
    for (int i = 0; i < 196; i++) if (cap[i] !== exp_byte(i, pc)) errs++;
    vectors += 3;
    if (en_cycles != 1) begin miscompares++; $display("FAIL step_en_cycles: got %0d, want 1", en_cycles); end
    if (nbytes != 196)  begin miscompares++; $display("FAIL step_nbytes: got %0d, want 196", nbytes); end
    if (errs != 0)      begin miscompares++; $display("FAIL step_dump: %0d bad bytes, want 0 (byte0=%h byte195=%h)", errs, cap[0], cap[195]); end
  endtask

  task automatic test_run();
    int errs;
    pc = 32'hA1B2_C3D4; halt = 1'b0; tx_delay = 1;
    clear_stats();
    send_cmd(8'h52);
    repeat (10) step();
    halt = 1'b1;
    #1;
    vectors++;
    if (clk_en !== 1'b0) begin miscompares++; $display("FAIL run_halt_clk_en: got %b, want 0", clk_en); end
    #1;
    step();
    vectors++;
    if (tx_start !== 1'b0) begin miscompares++; $display("FAIL run_load_tx_start: got %b, want 0", tx_start); end
    step();
    vectors += 2;
    if (tx_start !== 1'b1)  begin miscompares++; $display("FAIL run_first_tx_start: got %b, want 1", tx_start); end
    if (tx_data  !== 8'hD4) begin miscompares++; $display("FAIL run_first_byte: got %h, want d4", tx_data); end
    wait_idle(3000, "run");
    errs = 0;
    for (int i = 0; i < 196; i++) if (cap[i] !== exp_byte(i, pc)) errs++;
    vectors += 4;
    if (en_cycles != 10) begin miscompares++; $display("FAIL run_en_cycles: got %0d, want 10", en_cycles); end
    if (nbytes != 196)   begin miscompares++; $display("FAIL run_nbytes: got %0d, want 196", nbytes); end
    if ({cap[12], cap[13], cap[14], cap[15]} !== 32'h0202_0202)
      begin miscompares++; $display("FAIL run_reg2: got %h%h%h%h, want 02020202", cap[12], cap[13], cap[14], cap[15]); end
    if (errs != 0) begin miscompares++; $display("FAIL run_dump: %0d bad bytes, want 0", errs); end
  endtask

  task automatic test_run_halted();
    int errs;
    pc = 32'h1234_5678; halt = 1'b1; tx_delay = 0;
    clear_stats();
    send_cmd(8'h52);
    vectors += 2;
    if (clk_en !== 1'b0) begin miscompares++; $display("FAIL halted_clk_en: got %b, want 0", clk_en); end
    if (busy   !== 1'b1) begin miscompares++; $display("FAIL halted_busy: got %b, want 1", busy); end
    wait_idle(2000, "halted");
    errs = 0;
    for (int i = 0; i < 196; i++) if (cap[i] !== exp_byte(i, pc)) errs++;
    vectors += 3;
    if (en_cycles != 0) begin miscompares++; $display("FAIL halted_en_cycles: got %0d, want 0", en_cycles); end
    if (nbytes != 196)  begin miscompares++; $display("FAIL halted_nbytes: got %0d, want 196", nbytes); end
    if (errs != 0)      begin miscompares++; $display("FAIL halted_dump: %0d bad bytes, want 0", errs); end
    halt = 1'b0;
  endtask

  task automatic test_ignore();
    int errs;
    pc = 32'h0000_0100; halt = 1'b0; tx_delay = 2;
    clear_stats();
    send_cmd(8'h41);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL ign_unknown_busy: got %b, want 0", busy); end
    send_cmd(8'h53);
    repeat (20) step();
    send_cmd(8'h53);
    send_cmd(8'h52);
    wait_idle(3000, "ignore");
    repeat (20) step();
    errs = 0;
    for (int i = 0; i < 196; i++) if (cap[i] !== exp_byte(i, pc)) errs++;
    vectors += 4;
    if (busy !== 1'b0)  begin miscompares++; $display("FAIL ign_second_dump_busy: got %b, want 0", busy); end
    if (en_cycles != 1) begin miscompares++; $display("FAIL ign_en_cycles: got %0d, want 1", en_cycles); end
    if (nbytes != 196)  begin miscompares++; $display("FAIL ign_nbytes: got %0d, want 196", nbytes); end
    if (errs != 0)      begin miscompares++; $display("FAIL ign_dump: %0d bad bytes, want 0", errs); end
  endtask

  task automatic test_reset_mid();
    int n, errs;
    pc = 32'hCAFE_0008; halt = 1'b0; tx_delay = 0;
    clear_stats();
    send_cmd(8'h53);
    n = 0;
    while (nbytes < 101 && n < 1000) begin step(); n++; end
    vectors++;
    if (nbytes < 101) begin miscompares++; $display("FAIL mid_reach_byte100: got %0d bytes, want >=101", nbytes); end
    reset = 1'b0;
    #1;
    vectors += 5;
    if (clk_en   !== 1'b0)  begin miscompares++; $display("FAIL mid_rst_clk_en: got %b, want 0", clk_en); end
    if (tx_start !== 1'b0)  begin miscompares++; $display("FAIL mid_rst_tx_start: got %b, want 0", tx_start); end
    if (tx_data  !== 8'h00) begin miscompares++; $display("FAIL mid_rst_tx_data: got %h, want 00", tx_data); end
    if (word_addr !== 6'd0) begin miscompares++; $display("FAIL mid_rst_word_addr: got %0d, want 0", word_addr); end
    if (busy     !== 1'b0)  begin miscompares++; $display("FAIL mid_rst_busy: got %b, want 0", busy); end
    repeat (3) step();
    reset = 1'b1;
    repeat (3) step();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_no_retry_busy: got %b, want 0", busy); end
    clear_stats();
    send_cmd(8'h53);
    wait_idle(2000, "mid_redump");
    errs = 0;
    for (int i = 0; i < 196; i++) if (cap[i] !== exp_byte(i, pc)) errs++;
    vectors += 3;
    if (en_cycles != 1) begin miscompares++; $display("FAIL mid_en_cycles: got %0d, want 1", en_cycles); end
    if (nbytes != 196)  begin miscompares++; $display("FAIL mid_nbytes: got %0d, want 196", nbytes); end
    if (errs != 0)      begin miscompares++; $display("FAIL mid_dump: %0d bad bytes, want 0 (byte0=%h)", errs, cap[0]); end
  endtask

  task automatic test_slow_tx();
    int n, errs;
    pc = 32'h0000_00C3; halt = 1'b0; tx_delay = 1000;
    clear_stats();
    send_cmd(8'h53);
    n = 0;
    while (nbytes < 1 && n < 10) begin step(); n++; end
    repeat (500) step();
    vectors += 3;
    if (nbytes != 1)        begin miscompares++; $display("FAIL slow_hold_nbytes: got %0d, want 1", nbytes); end
    if (tx_start !== 1'b0)  begin miscompares++; $display("FAIL slow_hold_tx_start: got %b, want 0", tx_start); end
    if (tx_data  !== 8'hC3) begin miscompares++; $display("FAIL slow_hold_tx_data: got %h, want c3", tx_data); end
    n = 0;
    while (nbytes < 20 && n < 30000) begin step(); n++; end
    tx_delay = 0;
    wait_idle(5000, "slow");
    errs = 0;
    for (int i = 0; i < 196; i++) if (cap[i] !== exp_byte(i, pc)) errs++;
    vectors += 3;
    if (nbytes != 196) begin miscompares++; $display("FAIL slow_nbytes: got %0d, want 196", nbytes); end
    if (unstable != 0) begin miscompares++; $display("FAIL slow_tx_data_stable: got %0d changes, want 0", unstable); end
    if (errs != 0)     begin miscompares++; $display("FAIL slow_dump: %0d bad bytes, want 0", errs); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_run();
    test_run_halted();
    test_ignore();
    test_reset_mid();
    test_slow_tx();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
